// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - single-clock simple dual-port RAM with byte enables and clear sequencer
module ram_sdp_be #(
  parameter int RAM_WIDTH  = 16,
  parameter int RAM_DEPTH  = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [RAM_WIDTH/8-1:0]  wr_be,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [RAM_WIDTH-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [RAM_WIDTH-1:0]    rd_data,
  output logic                    rd_valid,
  output logic                    init_busy,
  output logic                    err_addr
);

  localparam int NB = RAM_WIDTH / 8;

  // Depth and last address widened by one bit so RAM_DEPTH == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = RAM_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LAST_W  = DEPTH_W - 1'b1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [RAM_WIDTH-1:0]  mem [RAM_DEPTH];

  logic                  wr_in;
  logic                  rd_in;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  oob_hit;
  logic [RAM_WIDTH-1:0]  rd_word;

  assign init_busy = (state == S_INIT);
  assign wr_in     = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in     = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_fire   = wr_en & ~init_busy & wr_in;
  assign rd_fire   = rd_en & ~init_busy;
  assign oob_hit   = (wr_en & ~init_busy & ~wr_in) | (rd_en & ~init_busy & ~rd_in);

  // Clear sequencer: walk every address once after reset, then run until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if ({1'b0, init_cnt} == LAST_W) begin
        state    <= S_RUN;
        init_cnt <= '0;
      end
    end
  end

  // Array write port: the clear sequencer owns the port while busy, then byte-lane user writes.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[init_cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Array read word: out-of-range reads give zero; bypass merges the enabled write lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in) rd_word = mem[rd_addr];
    if ((RDW_MODE != 0) && wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_addr <= 1'b0;
    else if (oob_hit) err_addr <= 1'b1;
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [RAM_WIDTH-1:0] s1_data;
      logic                 s1_valid;

      // Extra register stage on the array output; rd_data only moves when a result arrives.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_data  <= '0;
          s1_valid <= 1'b0;
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          s1_valid <= rd_fire;
          if (rd_fire) s1_data <= rd_word;
          rd_valid <= s1_valid;
          if (s1_valid) rd_data <= s1_data;
        end
      end
    end else begin : g_lat1
      // Single-stage read: array word captured on the accepting edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_fire;
          if (rd_fire) rd_data <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - directed self-checking bench for ram_sdp_be
module tb_ram_sdp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_be;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [8:0]  rd_addr;

  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic        a_busy, b_busy;
  logic        a_err, b_err;

  int n_cmp = 0;
  int n_err = 0;
  int na, nb;
  bit seen;

  always #5 clk = ~clk;

  // A: depth 512, latency 1, old-data read-during-write.
  ram_sdp_be #(.RAM_WIDTH(16), .RAM_DEPTH(512), .ADDR_WIDTH(9),
               .RD_LATENCY(1), .RDW_MODE(0), .INIT_CLEAR(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .init_busy(a_busy), .err_addr(a_err));

  // B: depth 500, latency 2, bypass read-during-write.
  ram_sdp_be #(.RAM_WIDTH(16), .RAM_DEPTH(500), .ADDR_WIDTH(9),
               .RD_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .init_busy(b_busy), .err_addr(b_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] data, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [8:0] addr,
                        input logic [15:0] exp_a, input logic [15:0] exp_b);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    rd_en = 1'b0;
    chk({tag, "_a_valid"}, a_rd_valid, 1);
    chk({tag, "_a_data"},  a_rd_data, exp_a);
    chk({tag, "_b_early"}, b_rd_valid, 0);
    tick();
    chk({tag, "_a_pulse"}, a_rd_valid, 0);
    chk({tag, "_b_valid"}, b_rd_valid, 1);
    chk({tag, "_b_data"},  b_rd_data, exp_b);
  endtask

  task automatic rdw(input string tag, input logic [15:0] d, input logic [1:0] be,
                     input logic [15:0] exp_a, input logic [15:0] exp_b);
    wr_en = 1'b1; wr_addr = 9'd7; wr_data = d; wr_be = be;
    rd_en = 1'b1; rd_addr = 9'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk({tag, "_a"}, a_rd_data, exp_a);
    tick();
    chk({tag, "_b"}, b_rd_data, exp_b);
  endtask

  // Counts cycles until each clear finishes; rd_en held while B is busy must give no rd_valid.
  task automatic wait_idle(output int cnt_a, output int cnt_b, output bit any_valid);
    cnt_a = 0; cnt_b = 0; any_valid = 0;
    rd_en = 1'b1; rd_addr = 9'd100;
    for (int i = 1; i <= 700; i++) begin
      tick();
      if (a_rd_valid || b_rd_valid) any_valid = 1;
      if (!b_busy && cnt_b == 0) begin
        cnt_b = i;
        rd_en = 1'b0;
      end
      if (!a_busy) begin
        cnt_a = i;
        break;
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_be = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    tick(); tick();
    chk("rst_a_data", a_rd_data, 0);
    chk("rst_a_valid", a_rd_valid, 0);
    chk("rst_a_busy", a_busy, 1);
    chk("rst_b_busy", b_busy, 1);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_err", b_err, 0);

    rst = 1'b0;
    wait_idle(na, nb, seen);
    chk("init_a_cycles", na, 512);
    chk("init_b_cycles", nb, 500);
    chk("init_no_valid", seen, 0);

    rd_chk("clear100", 9'd100, 16'h0000, 16'h0000);

    wr(9'd100, 16'h0006, 2'b11);
    rd_chk("wr100", 9'd100, 16'h0006, 16'h0006);

    wr(9'd5, 16'hABCD, 2'b11);
    wr(9'd5, 16'h1234, 2'b01);
    rd_chk("be_lo", 9'd5, 16'hAB34, 16'hAB34);
    wr(9'd5, 16'h77EE, 2'b00);
    rd_chk("be_none", 9'd5, 16'hAB34, 16'hAB34);

    wr(9'd7, 16'h1111, 2'b11);
    rdw("rdw_full", 16'h2222, 2'b11, 16'h1111, 16'h2222);
    wr(9'd7, 16'h1111, 2'b11);
    rdw("rdw_hi", 16'h2222, 2'b10, 16'h1111, 16'h2211);
    rd_chk("rdw_after", 9'd7, 16'h2211, 16'h2211);

    for (int i = 0; i < 4; i++) wr(i[8:0], 16'h00A0 + i[15:0], 2'b11);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = i[8:0];
      tick();
      chk("burst_a_valid", a_rd_valid, 1);
      chk("burst_a_data", a_rd_data, 16'h00A0 + i[15:0]);
      if (i == 0) chk("burst_b_wait", b_rd_valid, 0);
      else begin
        chk("burst_b_valid", b_rd_valid, 1);
        chk("burst_b_data", b_rd_data, 16'h00A0 + i[15:0] - 16'd1);
      end
    end
    rd_en = 1'b0;
    tick();
    chk("burst_a_end", a_rd_valid, 0);
    chk("burst_b_last_valid", b_rd_valid, 1);
    chk("burst_b_last_data", b_rd_data, 16'h00A3);
    tick();
    chk("burst_b_end", b_rd_valid, 0);
    chk("burst_hold", a_rd_data, 16'h00A3);

    wr(9'd505, 16'h5555, 2'b11);
    chk("oob_a_err", a_err, 0);
    chk("oob_b_err", b_err, 1);
    rd_chk("oob_rd", 9'd505, 16'h5555, 16'h0000);
    tick(); tick();
    chk("oob_b_sticky", b_err, 1);

    rd_en = 1'b1; rd_addr = 9'd100;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("flush_b_async", b_rd_valid, 0);
    tick();
    chk("flush_b_valid", b_rd_valid, 0);
    chk("flush_b_err", b_err, 0);
    chk("flush_a_data", a_rd_data, 0);
    rst = 1'b0;
    tick();
    chk("flush_after", b_rd_valid, 0);
    for (int i = 0; i < 199; i++) tick();
    chk("mid_busy", a_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle(na, nb, seen);
    chk("reinit_a_cycles", na, 512);
    chk("reinit_b_cycles", nb, 500);
    chk("reinit_no_valid", seen, 0);
    rd_chk("reclear100", 9'd100, 16'h0000, 16'h0000);
    rd_chk("reclear5", 9'd5, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
